keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per scan tick (1 kHz at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter DEBOUNCE, default 4, meaning consecutive matching ticks required to accept a press or a release; legal range >= 1.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rows, input, 4 bits: keypad row lines, active-low, asynchronous to clk.
REQ-006 SHALL have port cols, output, 4 bits: column drives, active-low, one-hot.
REQ-007 SHALL have port key_code, output, 4 bits: last accepted key, encoded {row_idx[1:0], col_idx[1:0]}.
REQ-008 SHALL have port key_int, output, 1 bit: key-available interrupt, level, held until acknowledged.
REQ-009 SHALL have port int_ack, input, 1 bit: one-cycle acknowledge from the MCU.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, a key was accepted while key_int was already high.

Function
REQ-011 SHALL synchronise rows through two flops before any use; all row decisions use the synchronised value.
REQ-012 SHALL count tick_cnt 0..TICK_DIV-1, wrapping to 0; an internal one-cycle tick asserts when tick_cnt == TICK_DIV-1, free-running in all states.
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE, HELD.
REQ-014 SHALL drive cols = ~(4'b0001 << col_idx) in every state; col_idx changes only in SCAN, or on DEBOUNCE abort.
REQ-015 SCAN, on tick: if all synchronised rows are high, col_idx increments mod 4 (3 wraps to 0); otherwise SHALL capture cand_row = lowest-index low row, clear deb_cnt, and go to DEBOUNCE with col_idx unchanged.
REQ-016 DEBOUNCE, on tick: if row cand_row is still low, deb_cnt increments; when the incremented value equals DEBOUNCE, SHALL latch key_code = {cand_row, col_idx}, set key_int, clear deb_cnt, and go to HELD. If row cand_row is high, SHALL return to SCAN with col_idx incremented mod 4.
REQ-017 With DEBOUNCE = 1, the key SHALL be accepted on the first DEBOUNCE tick; total latency from the detecting SCAN tick to key_int high is DEBOUNCE ticks plus 1 clk.
REQ-018 HELD, on tick: if all rows are high, deb_cnt increments, otherwise deb_cnt clears; when deb_cnt reaches DEBOUNCE, SHALL go to SCAN with col_idx incremented mod 4. No new key is accepted while in HELD.
REQ-019 int_ack high with key_int high SHALL clear key_int and overrun on the next edge; int_ack with key_int low SHALL be ignored.
REQ-020 A key latch while key_int is already high SHALL overwrite key_code and set overrun.
REQ-021 A key latch in the same cycle as int_ack SHALL win: key_int stays 1, key_code takes the new value, overrun becomes 0.
REQ-022 Multiple rows low in one column SHALL resolve to the lowest row index; other columns are not examined until the return to SCAN.
REQ-023 key_code SHALL change only on a key latch or on reset.

Reset
REQ-024 rst high at any clock edge, in any state and mid-debounce or mid-tick included, SHALL on that edge set: state = SCAN, col_idx = 0, cols = 4'b1110, tick_cnt = 0, deb_cnt = 0, key_code = 0, key_int = 0, overrun = 0, sync flops = 4'b1111.
REQ-025 After rst deasserts, the first tick SHALL occur TICK_DIV cycles later.

Verification
Bench uses TICK_DIV = 4 and DEBOUNCE = 3.
REQ-026 Idle: rows = 4'hF for 40 cycles -> cols cycles 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; key_int stays 0.
REQ-027 Press row 2 while col 1 is active, held for 20 ticks -> key_code = 4'b1001, key_int rises 3 ticks after the detecting tick plus 1 clk; cols stays 1101 until release plus 3 quiet ticks.
REQ-028 Glitch: row 0 low for 1 tick only -> FSM goes to DEBOUNCE then back to SCAN, col_idx advances, key_int stays 0.
REQ-029 Two presses (key 4'b0000, then 4'b0111) without int_ack -> key_code = 4'b0111, key_int = 1, overrun = 1; int_ack pulse -> key_int = 0 and overrun = 0 next cycle.
REQ-030 int_ack in the same cycle as a latch -> key_int remains 1, overrun = 0.
REQ-031 rst asserted during DEBOUNCE with a key held -> all outputs at reset values the next cycle; the key is re-detected from col 0 after reset.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks active-low columns on a divided tick,
// debounces press and release, and raises a level interrupt with overrun tracking.
module keypad_scan_ctrl #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_int,
  input  logic       int_ack,
  output logic       overrun
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_sync1, r_sync2;
  logic [TW-1:0]  r_tick_cnt;
  logic [1:0]     r_col_idx, w_col_nxt;
  logic [1:0]     r_cand_row, w_cand_nxt;
  logic [DW-1:0]  r_deb_cnt, w_deb_nxt;
  logic [DW-1:0]  w_deb_inc;
  logic [3:0]     r_key_code;
  logic           r_key_int;
  logic           r_overrun;
  logic           w_tick;
  logic           w_all_high;
  logic [1:0]     w_low_row;
  logic           w_latch;
  logic           w_ack;

  assign w_tick     = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_all_high = &r_sync2;
  assign w_deb_inc  = r_deb_cnt + 1'b1;
  assign w_ack      = int_ack & r_key_int;

  // Lowest-index low row wins when several rows are pulled low in one column.
  always_comb begin
    w_low_row = 2'd3;
    if (!r_sync2[0])      w_low_row = 2'd0;
    else if (!r_sync2[1]) w_low_row = 2'd1;
    else if (!r_sync2[2]) w_low_row = 2'd2;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col_idx;
    w_cand_nxt  = r_cand_row;
    w_deb_nxt   = r_deb_cnt;
    w_latch     = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (w_all_high) begin
            w_col_nxt = r_col_idx + 2'd1;
          end else begin
            w_cand_nxt  = w_low_row;
            w_deb_nxt   = '0;
            w_state_nxt = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!r_sync2[r_cand_row]) begin
            if (w_deb_inc == DW'(DEBOUNCE)) begin
              w_latch     = 1'b1;
              w_deb_nxt   = '0;
              w_state_nxt = ST_HELD;
            end else begin
              w_deb_nxt = w_deb_inc;
            end
          end else begin
            w_col_nxt   = r_col_idx + 2'd1;
            w_state_nxt = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (w_all_high) begin
            if (w_deb_inc == DW'(DEBOUNCE)) begin
              w_deb_nxt   = '0;
              w_col_nxt   = r_col_idx + 2'd1;
              w_state_nxt = ST_SCAN;
            end else begin
              w_deb_nxt = w_deb_inc;
            end
          end else begin
            w_deb_nxt = '0;
          end
        end
        default: w_state_nxt = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_tick_cnt <= '0;
      r_state    <= ST_SCAN;
      r_col_idx  <= '0;
      r_cand_row <= '0;
      r_deb_cnt  <= '0;
      r_key_code <= '0;
      r_key_int  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_sync1    <= rows;
      r_sync2    <= r_sync1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_state    <= w_state_nxt;
      r_col_idx  <= w_col_nxt;
      r_cand_row <= w_cand_nxt;
      r_deb_cnt  <= w_deb_nxt;
      // A latch coinciding with an acknowledge keeps the interrupt but clears overrun.
      if (w_latch) begin
        r_key_code <= {r_cand_row, r_col_idx};
        r_key_int  <= 1'b1;
        r_overrun  <= ~w_ack & (r_overrun | r_key_int);
      end else if (w_ack) begin
        r_key_int  <= 1'b0;
        r_overrun  <= 1'b0;
      end
    end
  end

  assign cols     = ~(4'b0001 << r_col_idx);
  assign key_code = r_key_code;
  assign key_int  = r_key_int;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: stimulus queues expected output
// changes (with the edge they must occur on); a monitor pops and compares them.
module tb_keypad_scan_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DEB      = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rows = 4'hF;
  logic       int_ack = 1'b0;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_int;
  logic       overrun;

  keypad_scan_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_int  (key_int),
    .int_ack  (int_ack),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release; edge 1 is the first edge with rst low.
  int n;
  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  typedef struct {
    int         en;
    logic [3:0] code;
    logic       kint;
    logic       ovr;
  } ev_t;

  ev_t exp_q[$];
  int  vectors    = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic expect_ev(input int en, input logic [3:0] c, input logic ki, input logic ov);
    ev_t e;
    e.en = en; e.code = c; e.kint = ki; e.ovr = ov;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int target);
    int guard = 0;
    while (n != target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (n != target) begin
      vectors++;
      miscompares++;
      $display("FAIL goto_timeout: got n=%0d expected n=%0d", n, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    int_ack = 1'b0;
    @(negedge clk);
    check("rst_cols", cols, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_int", key_int, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
  endtask

  task automatic end_scenario(input string name);
    ev_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s missing_event: got none expected n=%0d code=%b int=%b ovr=%b",
               name, e.en, e.code, e.kint, e.ovr);
    end
  endtask

  // Monitor: every change of {key_code,key_int,overrun} outside reset is a DUT output event.
  initial begin
    logic [5:0] prev;
    logic [5:0] cur;
    ev_t        e;
    prev = '0;
    forever begin
      @(posedge clk);
      #2;
      cur = {key_code, key_int, overrun};
      if (rst) begin
        prev = cur;
      end else if (cur !== prev) begin
        prev = cur;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: got n=%0d code=%b int=%b ovr=%b expected no change",
                   n, key_code, key_int, overrun);
        end else begin
          e = exp_q.pop_front();
          if (n != e.en || key_code !== e.code || key_int !== e.kint || overrun !== e.ovr) begin
            miscompares++;
            $display("FAIL event: got n=%0d code=%b int=%b ovr=%b expected n=%0d code=%b int=%b ovr=%b",
                     n, key_code, key_int, overrun, e.en, e.code, e.kint, e.ovr);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] exp_c;

    // Idle scan: column walks every TICK_DIV edges, first tick TICK_DIV edges after reset.
    do_reset();
    rows = 4'hF;
    for (int k = 0; k <= 40; k++) begin
      goto(k);
      exp_c = ~(4'b0001 << ((k / 4) % 4));
      check("idle_cols", cols, exp_c);
    end
    check("idle_key_int", key_int, 1'b0);
    end_scenario("idle");

    // Row 2 pressed in column 1, held, released, acknowledged.
    do_reset();
    expect_ev(20, 4'b1001, 1'b1, 1'b0);
    expect_ev(101, 4'b1001, 1'b0, 1'b0);
    goto(5);   rows = 4'b1011;
    goto(8);   check("press_cols_detect", cols, 4'b1101);
    goto(19);  check("press_int_before", key_int, 1'b0);
    goto(50);  check("press_cols_held", cols, 4'b1101);
    goto(85);  rows = 4'hF;
    goto(95);  check("press_cols_release", cols, 4'b1101);
    goto(96);  check("press_cols_resume", cols, 4'b1011);
    goto(100); int_ack = 1'b1;
    goto(101); int_ack = 1'b0;
    goto(105);
    end_scenario("press");

    // One-tick glitch on row 0: debounce aborts and the column advances.
    do_reset();
    goto(5);  rows = 4'b1110;
    goto(8);  check("glitch_cols_detect", cols, 4'b1101);
    goto(9);  rows = 4'hF;
    goto(12); check("glitch_cols_abort", cols, 4'b1011);
    goto(16); check("glitch_cols_next", cols, 4'b0111);
    goto(20); check("glitch_key_int", key_int, 1'b0);
    end_scenario("glitch");

    // Two keys without acknowledge: overrun, then ack clears both.
    do_reset();
    expect_ev(16, 4'b0000, 1'b1, 1'b0);
    expect_ev(52, 4'b0111, 1'b1, 1'b1);
    expect_ev(61, 4'b0111, 1'b0, 1'b0);
    rows = 4'b1110;
    goto(17); rows = 4'hF;
    goto(37); rows = 4'b1101;
    goto(40); check("ovr_cols_col3", cols, 4'b0111);
    goto(53); rows = 4'hF;
              check("ovr_overrun_set", overrun, 1'b1);
    goto(60); int_ack = 1'b1;
    goto(61); int_ack = 1'b0;
    goto(66);
    end_scenario("overrun");

    // Ack on the latch edge: interrupt held, overrun stays clear; later stray ack ignored.
    do_reset();
    expect_ev(16, 4'b0000, 1'b1, 1'b0);
    expect_ev(52, 4'b0111, 1'b1, 1'b0);
    expect_ev(61, 4'b0111, 1'b0, 1'b0);
    rows = 4'b1110;
    goto(17); rows = 4'hF;
    goto(37); rows = 4'b1101;
    goto(51); int_ack = 1'b1;
    goto(52); int_ack = 1'b0;
    goto(53); rows = 4'hF;
    goto(60); int_ack = 1'b1;
    goto(61); int_ack = 1'b0;
    goto(70); int_ack = 1'b1;
    goto(71); int_ack = 1'b0;
    goto(75); check("ackrace_key_int", key_int, 1'b0);
    end_scenario("ackrace");

    // Reset mid-debounce with a key held and a previous key latched; re-detect from column 0.
    do_reset();
    expect_ev(16, 4'b1000, 1'b1, 1'b0);
    rows = 4'b1011;
    goto(17); rows = 4'hF;
    goto(29); rows = 4'b1011;
    goto(34); check("rstdeb_cols_col1", cols, 4'b1101);
    end_scenario("rstdeb_pre");
    do_reset();
    expect_ev(16, 4'b1000, 1'b1, 1'b0);
    goto(8);  check("rstdeb_cols_col0", cols, 4'b1110);
    goto(20);
    end_scenario("rstdeb");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
